multi_sha256d_axi_regs: RTL and testbench

AXI4-Lite slave register file sitting directly upstream of the multi-core sha256d engine. Stores the 19-word block header, 8-word target and nonce range, and launches/aborts jobs. Captures done/found/nonce results for software readback.

---
 rtl/multi_sha256d_pkg.sv | 33 +++
 rtl/multi_sha256d_axi_regs.sv | 138 +++++++++++++
 tb/tb_multi_sha256d_axi_regs.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_sha256d_pkg.sv
// multi_sha256d_pkg: register map, field indices, response codes and FSM states for the sha256d register file.
package multi_sha256d_pkg;

    localparam int HDR_WORDS = 19;
    localparam int TGT_WORDS = 8;

    // word offsets (byte address >> 2)
    localparam logic [7:0] W_CTRL   = 8'h00;
    localparam logic [7:0] W_STATUS = 8'h01;
    localparam logic [7:0] W_NSTART = 8'h02;
    localparam logic [7:0] W_NEND   = 8'h03;
    localparam logic [7:0] W_FNONCE = 8'h04;
    localparam logic [7:0] W_TGT    = 8'h08;
    localparam logic [7:0] W_HDR    = 8'h10;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;
    localparam int ST_DONE    = 1;
    localparam int ST_FOUND   = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = strb[b] ? data[8*b +: 8] : old[8*b +: 8];
        return m;
    endfunction

endpackage

// File: rtl/multi_sha256d_axi_regs.sv
// multi_sha256d_axi_regs: AXI4-Lite register file holding header/target/nonce range and job control for the sha256d engine.
module multi_sha256d_axi_regs
    import multi_sha256d_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic                            core_start,
    output logic                            core_abort,
    output logic [32*HDR_WORDS-1:0]         core_header,
    output logic [32*TGT_WORDS-1:0]         core_target,
    output logic [63:0]                     core_range,
    input  logic                            core_busy,
    input  logic                            core_done,
    input  logic                            core_found,
    input  logic [31:0]                     core_nonce
);

    wr_state_t   w_state, w_next;
    rd_state_t   r_state, r_next;
    logic [31:0] header [HDR_WORDS];
    logic [31:0] target [TGT_WORDS];
    logic [31:0] nonce_start, nonce_end, found_nonce, rd_val;
    logic        done, found, busy, aw_hs, ar_hs, w_tgt, w_hdr, w_cfg, r_tgt, r_hdr;
    logic        start_req, abort_req, clr_done, clr_found, hit;
    logic [7:0]  w_word, r_word;
    logic [4:0]  wh_idx, rh_idx;

    // a launch is pending from the start pulse until the engine raises core_busy
    assign busy = core_busy | core_start;
    assign hit  = core_done & core_found;

    always_comb begin
        aw_hs  = (w_state == W_IDLE) && s00_axi_awvalid && s00_axi_wvalid;
        w_next = aw_hs ? W_RESP : (w_state == W_RESP && s00_axi_bready) ? W_IDLE : w_state;
        ar_hs  = (r_state == R_IDLE) && s00_axi_arvalid;
        r_next = ar_hs ? R_DATA : (r_state == R_DATA && s00_axi_rready) ? R_IDLE : r_state;
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    assign s00_axi_awready = aw_hs;
    assign s00_axi_wready  = aw_hs;
    assign s00_axi_arready = ar_hs;
    assign s00_axi_bvalid  = w_state == W_RESP;
    assign s00_axi_rvalid  = r_state == R_DATA;
    assign s00_axi_rresp   = RESP_OKAY;

    assign w_word    = 8'(s00_axi_awaddr >> 2);
    assign r_word    = 8'(s00_axi_araddr >> 2);
    assign wh_idx    = 5'(w_word - W_HDR);
    assign rh_idx    = 5'(r_word - W_HDR);
    assign w_tgt     = w_word >= W_TGT && w_word < W_TGT + 8'(TGT_WORDS);
    assign w_hdr     = w_word >= W_HDR && w_word < W_HDR + 8'(HDR_WORDS);
    assign r_tgt     = r_word >= W_TGT && r_word < W_TGT + 8'(TGT_WORDS);
    assign r_hdr     = r_word >= W_HDR && r_word < W_HDR + 8'(HDR_WORDS);
    assign w_cfg     = w_tgt || w_hdr || w_word == W_NSTART || w_word == W_NEND;
    assign start_req = aw_hs && w_word == W_CTRL && s00_axi_wstrb[0] && s00_axi_wdata[CTRL_START]
                       && !s00_axi_wdata[CTRL_ABORT] && !busy;
    assign abort_req = aw_hs && w_word == W_CTRL && s00_axi_wstrb[0] && s00_axi_wdata[CTRL_ABORT];
    assign clr_done  = aw_hs && w_word == W_STATUS && s00_axi_wstrb[0] && s00_axi_wdata[ST_DONE];
    assign clr_found = aw_hs && w_word == W_STATUS && s00_axi_wstrb[0] && s00_axi_wdata[ST_FOUND];

    always_comb begin
        rd_val = r_word == W_STATUS ? {29'd0, found, done, busy} :
                 r_word == W_NSTART ? nonce_start :
                 r_word == W_NEND   ? nonce_end :
                 r_word == W_FNONCE ? found_nonce :
                 r_tgt              ? target[r_word[2:0]] :
                 r_hdr              ? header[rh_idx] : 32'd0;
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_bresp <= RESP_OKAY;
            s00_axi_rdata <= '0;
            core_start    <= 1'b0;
            core_abort    <= 1'b0;
            done          <= 1'b0;
            found         <= 1'b0;
            found_nonce   <= '0;
            nonce_start   <= '0;
            nonce_end     <= '0;
            for (int k = 0; k < HDR_WORDS; k++) header[k] <= '0;
            for (int k = 0; k < TGT_WORDS; k++) target[k] <= '0;
        end else begin
            core_start  <= start_req;
            core_abort  <= abort_req;
            done        <= core_done ? 1'b1 : (start_req || clr_done) ? 1'b0 : done;
            found       <= hit ? 1'b1 : (start_req || clr_found) ? 1'b0 : found;
            found_nonce <= hit ? core_nonce : found_nonce;
            if (aw_hs) s00_axi_bresp <= (w_cfg && busy) ? RESP_SLVERR : RESP_OKAY;
            if (ar_hs) s00_axi_rdata <= rd_val;
            if (aw_hs && !busy) begin
                if (w_word == W_NSTART) nonce_start <= merge(nonce_start, s00_axi_wdata, s00_axi_wstrb);
                if (w_word == W_NEND) nonce_end <= merge(nonce_end, s00_axi_wdata, s00_axi_wstrb);
                if (w_tgt) target[w_word[2:0]] <= merge(target[w_word[2:0]], s00_axi_wdata, s00_axi_wstrb);
                if (w_hdr) header[wh_idx] <= merge(header[wh_idx], s00_axi_wdata, s00_axi_wstrb);
            end
        end
    end

    for (genvar i = 0; i < HDR_WORDS; i++) begin : g_hdr
        assign core_header[32*i +: 32] = header[i];
    end
    for (genvar i = 0; i < TGT_WORDS; i++) begin : g_tgt
        assign core_target[32*i +: 32] = target[i];
    end
    assign core_range = {nonce_end, nonce_start};

endmodule

// File: tb/tb_multi_sha256d_axi_regs.sv
// tb_multi_sha256d_axi_regs: directed checks of the sha256d AXI register file.
module tb_multi_sha256d_axi_regs;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic [7:0]   awaddr, araddr;
    logic         awvalid, awready, wready, wvalid, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic         core_start, core_abort, core_busy, core_done, core_found;
    logic [607:0] core_header;
    logic [255:0] core_target;
    logic [63:0]  core_range;
    logic [31:0]  core_nonce;
    int           checks = 0, errs = 0, start_cnt = 0, abort_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (core_start) start_cnt++;
        if (core_abort) abort_cnt++;
    end

    multi_sha256d_axi_regs dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .core_start(core_start), .core_abort(core_abort), .core_header(core_header),
        .core_target(core_target), .core_range(core_range), .core_busy(core_busy),
        .core_done(core_done), .core_found(core_found), .core_nonce(core_nonce)
    );

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        #1;
        while (!awready && n < 50) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            checks++; errs++;
            $display("FAIL write_timeout addr=%h got no handshake, required one within 50 cycles", a);
        end
        resp = bresp;
        @(posedge clk); #1;
        bready = 0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1; rready = 1;
        #1;
        while (!arready && n < 50) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        arvalid = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            checks++; errs++;
            $display("FAIL read_timeout addr=%h got no data, required within 50 cycles", a);
        end
        d = rdata; resp = rresp;
        @(posedge clk); #1;
        rready = 0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [1:0]  r;
        #200;
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, core_start, core_abort} !== 7'd0) begin
            errs++; $display("FAIL reset_ctl got %b required 0", {awready, wready, bvalid, arready, rvalid, core_start, core_abort});
        end
        checks++;
        if ({bresp, rresp, rdata} !== 36'd0) begin
            errs++; $display("FAIL reset_bus got %h required 0", {bresp, rresp, rdata});
        end
        checks++;
        if ({core_header, core_target, core_range} !== '0) begin
            errs++; $display("FAIL reset_core_cfg got nonzero required 0");
        end
        @(negedge clk); rst_n = 1;
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h0) begin errs++; $display("FAIL reset_status got %h required 0", d); end
        axi_read(8'h10, d, r);
        checks++;
        if (d !== 32'h0) begin errs++; $display("FAIL reset_found_nonce got %h required 0", d); end
    endtask

    task automatic test_regs;
        logic [31:0] d;
        logic [1:0]  r;
        for (int i = 0; i < 19; i++) axi_write(8'(8'h40 + 4*i), 32'(i + 1), 4'hF, r);
        for (int i = 0; i < 8; i++) axi_write(8'(8'h20 + 4*i), 32'(8'hA0 + i), 4'hF, r);
        for (int i = 0; i < 19; i++) begin
            axi_read(8'(8'h40 + 4*i), d, r);
            checks++;
            if (d !== 32'(i + 1)) begin errs++; $display("FAIL header_rb[%0d] got %h required %h", i, d, i + 1); end
        end
        for (int i = 0; i < 8; i++) begin
            axi_read(8'(8'h20 + 4*i), d, r);
            checks++;
            if (d !== 32'(8'hA0 + i)) begin errs++; $display("FAIL target_rb[%0d] got %h required %h", i, d, 8'hA0 + i); end
        end
        checks++;
        if (core_header[31:0] !== 32'h1) begin errs++; $display("FAIL core_header_w0 got %h required 1", core_header[31:0]); end
        checks++;
        if (core_header[607:576] !== 32'h13) begin errs++; $display("FAIL core_header_w18 got %h required 13", core_header[607:576]); end
        checks++;
        if (core_target[255:224] !== 32'hA7) begin errs++; $display("FAIL core_target_w7 got %h required a7", core_target[255:224]); end
    endtask

    task automatic test_strobe;
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(8'h08, 32'h11223344, 4'hF, r);
        axi_write(8'h08, 32'hDEADBEEF, 4'b0010, r);
        axi_read(8'h08, d, r);
        checks++;
        if (d !== 32'h1122BE44) begin errs++; $display("FAIL strobe_merge got %h required 1122be44", d); end
        axi_write(8'h0C, 32'h00000005, 4'hF, r);
        checks++;
        if (core_range !== 64'h00000005_1122BE44) begin errs++; $display("FAIL core_range got %h required 000000051122be44", core_range); end
        axi_write(8'h9C, 32'hFFFFFFFF, 4'hF, r);
        checks++;
        if (r !== 2'b00) begin errs++; $display("FAIL unmapped_bresp got %b required 00", r); end
        axi_read(8'h9C, d, r);
        checks++;
        if (d !== 32'h0) begin errs++; $display("FAIL unmapped_read got %h required 0", d); end
    endtask

    task automatic test_start_lock;
        logic [31:0] d;
        logic [1:0]  r;
        int s0 = start_cnt;
        axi_write(8'h00, 32'h1, 4'hF, r);
        checks++;
        if (r !== 2'b00) begin errs++; $display("FAIL start_bresp got %b required 00", r); end
        @(negedge clk); core_busy = 1;
        axi_write(8'h40, 32'h55, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin errs++; $display("FAIL lock_bresp got %b required 10", r); end
        axi_read(8'h40, d, r);
        checks++;
        if (d !== 32'h1) begin errs++; $display("FAIL lock_header0 got %h required 1", d); end
        axi_write(8'h00, 32'h1, 4'hF, r);
        checks++;
        if (r !== 2'b00) begin errs++; $display("FAIL busy_start_bresp got %b required 00", r); end
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h1) begin errs++; $display("FAIL busy_status got %h required 1", d); end
        checks++;
        if (start_cnt - s0 !== 1) begin errs++; $display("FAIL start_pulses got %0d required 1", start_cnt - s0); end
    endtask

    task automatic test_abort;
        logic [1:0] r;
        int s0 = start_cnt, a0 = abort_cnt;
        @(negedge clk); core_busy = 0;
        axi_write(8'h00, 32'h3, 4'hF, r);
        repeat (2) @(negedge clk);
        checks++;
        if (abort_cnt - a0 !== 1) begin errs++; $display("FAIL abort_pulses got %0d required 1", abort_cnt - a0); end
        checks++;
        if (start_cnt - s0 !== 0) begin errs++; $display("FAIL abort_no_start got %0d required 0", start_cnt - s0); end
    endtask

    task automatic test_done;
        logic [31:0] d;
        logic [1:0]  r;
        int n = 0;
        @(negedge clk); core_done = 1; core_found = 1; core_nonce = 32'h0badf00d;
        @(negedge clk); core_done = 0; core_found = 0; core_nonce = 32'h0;
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h6) begin errs++; $display("FAIL done_status got %h required 6", d); end
        axi_read(8'h10, d, r);
        checks++;
        if (d !== 32'h0badf00d) begin errs++; $display("FAIL found_nonce got %h required 0badf00d", d); end
        @(negedge clk);
        awaddr = 8'h04; wdata = 32'h6; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        core_done = 1; core_found = 1; core_nonce = 32'h0badf00d;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; core_done = 0; core_found = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bready = 0;
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h6) begin errs++; $display("FAIL w1c_vs_done got %h required 6", d); end
        axi_write(8'h04, 32'h6, 4'hF, r);
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h0) begin errs++; $display("FAIL w1c_clear got %h required 0", d); end
        axi_read(8'h10, d, r);
        checks++;
        if (d !== 32'h0badf00d) begin errs++; $display("FAIL found_nonce_hold got %h required 0badf00d", d); end
        @(negedge clk); core_done = 1; core_nonce = 32'h12345678;
        @(negedge clk); core_done = 0;
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h2) begin errs++; $display("FAIL done_no_found got %h required 2", d); end
        axi_read(8'h10, d, r);
        checks++;
        if (d !== 32'h0badf00d) begin errs++; $display("FAIL miss_keeps_nonce got %h required 0badf00d", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic [1:0]  r;
        logic        held = 1, acc = 0;
        int          n = 0;
        @(negedge clk);
        awaddr = 8'h0C; wdata = 32'h1111; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        repeat (10) begin @(negedge clk); if (!bvalid) held = 0; end
        checks++;
        if (held !== 1'b1) begin errs++; $display("FAIL bvalid_hold got dropped required held 10 cycles"); end
        awaddr = 8'h0C; wdata = 32'h2222; awvalid = 1; wvalid = 1;
        repeat (3) begin #1; if (awready) acc = 1; @(negedge clk); end
        checks++;
        if (acc !== 1'b0) begin errs++; $display("FAIL accept_while_bvalid got accepted required stalled"); end
        axi_read(8'hFC, d, r);
        checks++;
        if ({d, r} !== 34'd0) begin errs++; $display("FAIL read_fc got %h/%b required 0/00", d, r); end
        checks++;
        if (bvalid !== 1'b1) begin errs++; $display("FAIL bvalid_during_read got %b required 1", bvalid); end
        @(negedge clk); bready = 1;
        #1;
        while (!awready && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if (n >= 20) begin errs++; $display("FAIL second_accept got none required accepted after bready"); end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        @(posedge clk); #1;
        bready = 0;
        axi_read(8'h0C, d, r);
        checks++;
        if (d !== 32'h2222) begin errs++; $display("FAIL second_write_value got %h required 2222", d); end
    endtask

    initial begin
        awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        araddr = 0; arvalid = 0; rready = 0;
        core_busy = 0; core_done = 0; core_found = 0; core_nonce = 0;
        test_reset;
        test_regs;
        test_strobe;
        test_start_lock;
        test_abort;
        test_done;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

endmodule
